// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: one shared decoder, NUM_DIGITS digits,
// double-buffered frame contents swapped only at frame boundaries.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 2,
    parameter int SEG_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [3*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_mask,
    output logic [2:0]              seg_code,
    output logic                    seg_en,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int DW   = 3 * NUM_DIGITS;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [IW-1:0]         idx_r, idx_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [DW-1:0]         act_code_r, act_code_s;
    logic [NUM_DIGITS-1:0] act_mask_r, act_mask_s;
    logic [DW-1:0]         shd_code_r, shd_code_s;
    logic [NUM_DIGITS-1:0] shd_mask_r, shd_mask_s;
    logic                  pending_r, pending_s;
    logic                  load_ready_r, load_ready_s;
    logic [2:0]            seg_code_r, seg_code_s;
    logic                  seg_en_r, seg_en_s;
    logic [NUM_DIGITS-1:0] sel_r, sel_s;
    logic                  frame_done_r, frame_done_s;

    logic                  accept_s;
    logic                  frame_end_s;
    logic [2:0]            code_pick_s;
    logic                  en_pick_s;
    logic [NUM_DIGITS-1:0] onehot_s;

    // Next-state, buffer management and next values of the registered outputs.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        act_code_s = act_code_r;
        act_mask_s = act_mask_r;
        shd_code_s = shd_code_r;
        shd_mask_s = shd_mask_r;
        pending_s  = pending_r;
        code_pick_s = 3'd0;
        en_pick_s   = 1'b0;
        onehot_s    = {NUM_DIGITS{1'b0}};

        accept_s    = load_valid & load_ready_r;
        frame_end_s = (state_r == ST_BLANK) && (idx_r == LAST_IDX) && (cnt_r == {CW{1'b0}});

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    act_code_s = load_data;
                    act_mask_s = load_mask;
                    state_s    = ST_SHOW;
                    idx_s      = {IW{1'b0}};
                    cnt_s      = DWELL_LD;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ST_BLANK;
                    cnt_s   = BLANK_LD;
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                end
                if (accept_s) begin
                    shd_code_s = load_data;
                    shd_mask_s = load_mask;
                    pending_s  = 1'b1;
                end else begin
                    pending_s  = pending_r;
                end
            end
            ST_BLANK: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ST_SHOW;
                    idx_s   = (idx_r == LAST_IDX) ? {IW{1'b0}} : idx_r + IW'(1);
                    cnt_s   = DWELL_LD;
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                end
                // A load offered exactly at the boundary goes straight to active.
                if (frame_end_s && pending_r) begin
                    act_code_s = shd_code_r;
                    act_mask_s = shd_mask_r;
                    pending_s  = 1'b0;
                end else if (frame_end_s && accept_s) begin
                    act_code_s = load_data;
                    act_mask_s = load_mask;
                end else if (accept_s) begin
                    shd_code_s = load_data;
                    shd_mask_s = load_mask;
                    pending_s  = 1'b1;
                end else begin
                    pending_s  = pending_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                idx_s     = {IW{1'b0}};
                cnt_s     = {CW{1'b0}};
                pending_s = 1'b0;
            end
        endcase

        for (int i = 0; i < NUM_DIGITS; i++) begin
            code_pick_s = (idx_s == IW'(i)) ? act_code_s[3*i +: 3] : code_pick_s;
            en_pick_s   = (idx_s == IW'(i)) ? act_mask_s[i] : en_pick_s;
            onehot_s[i] = (idx_s == IW'(i));
        end

        seg_en_s     = (state_s == ST_SHOW) && en_pick_s;
        seg_code_s   = seg_en_s ? code_pick_s : 3'd0;
        sel_s        = seg_en_s ? onehot_s : {NUM_DIGITS{1'b0}};
        frame_done_s = (state_s == ST_BLANK) && (idx_s == LAST_IDX) && (cnt_s == {CW{1'b0}});
        load_ready_s = (state_s == ST_IDLE) ? 1'b1 : !pending_s;
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            act_code_r   <= {DW{1'b0}};
            act_mask_r   <= {NUM_DIGITS{1'b0}};
            shd_code_r   <= {DW{1'b0}};
            shd_mask_r   <= {NUM_DIGITS{1'b0}};
            pending_r    <= 1'b0;
            load_ready_r <= 1'b0;
            seg_code_r   <= 3'd0;
            seg_en_r     <= 1'b0;
            sel_r        <= {NUM_DIGITS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            act_code_r   <= act_code_s;
            act_mask_r   <= act_mask_s;
            shd_code_r   <= shd_code_s;
            shd_mask_r   <= shd_mask_s;
            pending_r    <= pending_s;
            load_ready_r <= load_ready_s;
            seg_code_r   <= seg_code_s;
            seg_en_r     <= seg_en_s;
            sel_r        <= sel_s;
            frame_done_r <= frame_done_s;
        end
    end

    // digit_sel trails seg_en by the decoder latency so segments and drive line up.
    generate
        if (SEG_LAT == 0) begin : g_nolat
            assign digit_sel = sel_r;
        end else begin : g_lat
            logic [NUM_DIGITS-1:0] pipe_r [SEG_LAT];

            // Digit-select delay line.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < SEG_LAT; k++) begin
                        pipe_r[k] <= {NUM_DIGITS{1'b0}};
                    end
                end else begin
                    pipe_r[0] <= sel_r;
                    for (int k = 1; k < SEG_LAT; k++) begin
                        pipe_r[k] <= pipe_r[k-1];
                    end
                end
            end

            assign digit_sel = pipe_r[SEG_LAT-1];
        end
    endgenerate

    assign load_ready = load_ready_r;
    assign seg_code   = seg_code_r;
    assign seg_en     = seg_en_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK=1, SEG_LAT=2.
// A frame is 20 cycles: digit d occupies cycles 5d..5d+4, the last of which is blank.
module tb_sevenseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [11:0] load_data;
    logic [3:0]  load_mask;
    logic [2:0]  seg_code;
    logic        seg_en;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Expected undelayed digit select of the previous two cycles.
    logic [3:0] ed1, ed2;

    localparam logic [11:0] CODES_A0 = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [11:0] CODES_7  = {3'd7, 3'd7, 3'd7, 3'd7};
    localparam logic [11:0] CODES_A  = {3'd1, 3'd6, 3'd5, 3'd4};
    localparam logic [11:0] CODES_B  = {3'd5, 3'd4, 3'd3, 3'd2};
    localparam logic [11:0] CODES_C  = {3'd7, 3'd0, 3'd7, 3'd0};
    localparam logic [11:0] CODES_D  = {3'd4, 3'd3, 3'd2, 3'd1};

    sevenseg_scan_ctrl #(
        .NUM_DIGITS(4),
        .DWELL     (4),
        .BLANK     (1),
        .SEG_LAT   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .load_mask (load_mask),
        .seg_code  (seg_code),
        .seg_en    (seg_en),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".load_ready"}, 0, {7'd0, load_ready}, 8'd0);
        chk({tag, ".seg_code"},   0, {5'd0, seg_code},   8'd0);
        chk({tag, ".seg_en"},     0, {7'd0, seg_en},     8'd0);
        chk({tag, ".digit_sel"},  0, {4'd0, digit_sel},  8'd0);
        chk({tag, ".frame_done"}, 0, {7'd0, frame_done}, 8'd0);
    endtask

    task automatic check_idle(input string tag, input int c, input logic exp_ready);
        chk({tag, ".seg_en"},     c, {7'd0, seg_en},     8'd0);
        chk({tag, ".seg_code"},   c, {5'd0, seg_code},   8'd0);
        chk({tag, ".digit_sel"},  c, {4'd0, digit_sel},  {4'd0, ed2});
        chk({tag, ".frame_done"}, c, {7'd0, frame_done}, 8'd0);
        chk({tag, ".load_ready"}, c, {7'd0, load_ready}, {7'd0, exp_ready});
        ed2 = ed1;
        ed1 = 4'b0000;
    endtask

    task automatic check_cycle(input string tag, input int c, input logic [11:0] codes,
                               input logic [3:0] mask, input logic exp_ready);
        int         d;
        logic       show;
        logic       en;
        logic [2:0] code;
        logic [3:0] cur;
        d    = c / 5;
        show = ((c % 5) < 4);
        en   = show && mask[d];
        code = en ? codes[3*d +: 3] : 3'd0;
        cur  = en ? (4'b0001 << d) : 4'b0000;
        chk({tag, ".seg_en"}, c, {7'd0, seg_en}, {7'd0, en});
        if (!show || en) begin
            chk({tag, ".seg_code"}, c, {5'd0, seg_code}, {5'd0, code});
        end
        chk({tag, ".digit_sel"},  c, {4'd0, digit_sel},  {4'd0, ed2});
        chk({tag, ".frame_done"}, c, {7'd0, frame_done}, {7'd0, (c == 19)});
        chk({tag, ".load_ready"}, c, {7'd0, load_ready}, {7'd0, exp_ready});
        ed2 = ed1;
        ed1 = cur;
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 12'd0;
        load_mask  = 4'd0;
        ed1        = 4'b0000;
        ed2        = 4'b0000;

        tick;
        tick;
        check_reset("reset");

        rst_n = 1'b1;
        tick;
        check_idle("post_reset", 0, 1'b1);
        tick;
        check_idle("idle", 1, 1'b1);

        // Basic scan, loaded from IDLE.
        load_valid = 1'b1;
        load_data  = CODES_A0;
        load_mask  = 4'b1111;
        tick;
        load_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check_cycle("basic", c, CODES_A0, 4'b1111, 1'b1);
            tick;
        end

        // Load offered in cycle 7; the frame finishes with the old codes.
        for (int c = 0; c < 20; c++) begin
            check_cycle("midload", c, CODES_A0, 4'b1111, (c < 8));
            load_valid = (c == 7);
            load_data  = (c == 7) ? CODES_7 : 12'd0;
            load_mask  = 4'b1111;
            tick;
        end

        // New codes shown; a masked load at cycle 3, then changing data held under backpressure.
        for (int c = 0; c < 20; c++) begin
            check_cycle("newframe", c, CODES_7, 4'b1111, (c < 4));
            load_valid = (c >= 3);
            load_data  = (c == 3) ? CODES_A : {4{3'(c)}};
            load_mask  = (c == 3) ? 4'b0101 : 4'b1010;
            tick;
        end

        // Masked frame; the held load is accepted only on the cycle after frame_done.
        for (int c = 0; c < 20; c++) begin
            check_cycle("mask", c, CODES_A, 4'b0101, (c == 0));
            load_valid = (c == 0);
            load_data  = (c == 0) ? CODES_B : 12'd0;
            load_mask  = 4'b1111;
            tick;
        end

        // Backpressured load appears; a further load goes pending, then reset during digit 2.
        for (int c = 0; c < 12; c++) begin
            check_cycle("preset", c, CODES_B, 4'b1111, (c < 4));
            load_valid = (c == 3);
            load_data  = (c == 3) ? CODES_C : 12'd0;
            load_mask  = 4'b1111;
            tick;
        end
        rst_n      = 1'b0;
        load_valid = 1'b0;
        tick;
        check_reset("midreset");
        ed1   = 4'b0000;
        ed2   = 4'b0000;
        rst_n = 1'b1;
        tick;
        check_idle("rst_release", 0, 1'b1);

        // Pending codes are discarded: the controller stays idle and dark.
        for (int c = 1; c < 25; c++) begin
            check_idle("after_rst", c, 1'b1);
            tick;
        end

        load_valid = 1'b1;
        load_data  = CODES_D;
        load_mask  = 4'b1111;
        tick;
        load_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check_cycle("reload", c, CODES_D, 4'b1111, 1'b1);
            tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_DIGITS, 4, digits multiplexed onto one shared sevenseg decoder (2..8).
- DWELL, 1000, cycles each digit is shown per frame (>=1).
- BLANK, 2, blanking cycles after each digit (>=1).
- SEG_LAT, 2, decoder pipeline latency in cycles that digit_sel is delayed by (0..4).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all logic on its rising edge.
- rst_n, in, 1, reset; synchronous and active-low.
- load_valid, in, 1, new frame contents offered.
- load_ready, out, 1, controller can accept a load.
- load_data, in, 3*NUM_DIGITS, digit codes; digit i is bits [3i+2:3i].
- load_mask, in, NUM_DIGITS, per-digit enable; 0 blanks that digit.
- seg_code, out, 3, code to decoder segin.
- seg_en, out, 1, decoder enable.
- digit_sel, out, NUM_DIGITS, one-hot digit drive, aligned to decoder output.
- frame_done, out, 1, one-cycle pulse on the last cycle of each frame.

Function
REQ-003 The FSM SHALL have three states: IDLE, SHOW, BLANK. It SHALL also hold a digit index (0..NUM_DIGITS-1) and a dwell/blank down-counter.
REQ-004 A load SHALL be accepted in a cycle where load_valid and load_ready are both 1.
REQ-005 In IDLE, load_ready SHALL be 1.
- An accepted load SHALL write the active code and mask registers directly.
- The FSM SHALL enter SHOW with index 0 on the next cycle.
REQ-006 In SHOW or BLANK, an accepted load SHALL write a shadow register and set pending.
- load_ready SHALL equal !pending, registered, so it goes 0 in the cycle after acceptance.
REQ-007 Transitions:
- SHOW lasts exactly DWELL cycles, then moves to BLANK.
- BLANK lasts exactly BLANK cycles, then moves to SHOW with index+1.
- From the last digit, the index wraps to 0.
REQ-008 On the final BLANK cycle of index NUM_DIGITS-1, frame_done SHALL be 1 for that cycle only.
- If pending, active SHALL be loaded from shadow, pending SHALL clear, and load_ready SHALL return to 1 on the next cycle.
REQ-009 Active contents SHALL never change mid-frame. A frame is NUM_DIGITS*(DWELL+BLANK) cycles.
REQ-010 Outputs SHALL be registered Moore outputs of the current state.
- In SHOW index i: seg_code = active code i; seg_en = mask[i].
- In IDLE and BLANK: seg_code = 0; seg_en = 0.
REQ-011 digit_sel SHALL equal onehot(i) AND mask[i] during SHOW and 0 otherwise, delayed by exactly SEG_LAT cycles through a shift pipeline.
- With SEG_LAT=0 it SHALL be undelayed.
REQ-012 A masked digit SHALL still consume its full DWELL+BLANK slot, so frame timing is independent of mask.
REQ-013 A load with load_mask all zero SHALL be legal. The FSM keeps scanning with every output 0 except frame_done.
REQ-014 The controller SHALL never leave SHOW/BLANK back to IDLE except on reset.

Reset
REQ-015 While rst_n=0 at a clk edge:
- State SHALL be IDLE, index 0, counter cleared.
- Active, shadow and pending SHALL be cleared, along with the digit_sel pipeline.
- Outputs SHALL be: load_ready=0, seg_code=0, seg_en=0, digit_sel=0, frame_done=0.
REQ-016 load_ready SHALL be 1 from the first cycle after rst_n returns to 1.
REQ-017 Reset asserted mid-frame SHALL abort the frame immediately. Any pending load SHALL be discarded and no frame_done SHALL be issued.

Verification
Bench parameters: NUM_DIGITS=4, DWELL=4, BLANK=1, SEG_LAT=2.
REQ-018 Basic scan: load codes {3,2,1,0}, mask 4'b1111 in IDLE.
- Index 0 shows seg_code 0 for 4 cycles, then seg_en=0 for 1 cycle, then code 1, and so on.
- frame_done pulses every 20 cycles.
- digit_sel 0001/0010/0100/1000 each lags seg_en by exactly 2 cycles.
REQ-019 Mid-frame load: in cycle 7 of a frame, load {7,7,7,7}.
- load_ready=0 from cycle 8 until the frame_done cycle.
- The current frame finishes with the old codes.
- The next frame shows 7 on all digits, and load_ready=1 again.
REQ-020 Masking: load_mask 4'b0101.
- Digits 1 and 3 show seg_en=0 and digit_sel=0 during their slots.
- Frame length stays 20 cycles.
REQ-021 Backpressure: hold load_valid=1 with changing data while pending=1.
- No acceptance occurs.
- Exactly one load is accepted per frame boundary, on the cycle after frame_done.
REQ-022 Reset mid-frame: drop rst_n for 1 cycle during digit 2 with a load pending.
- All outputs are 0 and the state is IDLE.
- load_ready=1 next cycle.
- The pending codes are never displayed.
